prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream ingress plus memory-write and boot-status egress of the program loader.
interface prog_loader_if #(
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] byte_in;
   logic         byte_valid;
   logic         byte_ready;
   logic         mem_write;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_data;
   logic         cpu_rst_n;
   logic         done;
   logic         error;

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, mem_write, mem_addr, mem_data, cpu_rst_n, done, error
   );

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, mem_write, mem_addr, mem_data, cpu_rst_n, done, error
   );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: takes a (length, payload, checksum) byte frame, writes the payload to memory,
// and releases the processor from reset only after the checksum matches.
module prog_loader #(
   parameter int                   WORD_SIZE      = 8,
   parameter logic [WORD_SIZE-1:0] LOAD_BASE      = '0,
   parameter int                   TIMEOUT_CYCLES = 1024
) (
   input  logic          clk,
   input  logic          rst,
   prog_loader_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

   localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

   state_e               state_q, state_d;
   logic [WORD_SIZE-1:0] len_q, len_d;
   logic [WORD_SIZE-1:0] idx_q, idx_d;
   logic [WORD_SIZE-1:0] csum_q, csum_d;
   logic [15:0]          timer_q, timer_d;
   logic                 mem_write_q, mem_write_d;
   logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
   logic                 cpu_rst_n_q, cpu_rst_n_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;

   logic        ready;
   logic        accept;
   logic [16:0] tmr_inc;

   assign ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept  = ready && bus.byte_valid;
   assign tmr_inc = {1'b0, timer_q} + 17'd1;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      csum_d      = csum_q;
      timer_d     = timer_q;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      cpu_rst_n_d = cpu_rst_n_q;
      done_d      = done_q;
      error_d     = error_q;

      // Idle timer; an acceptance on the timeout edge takes priority via the case below.
      if (ready) begin
         if (accept) begin
            timer_d = '0;
         end else begin
            timer_d = tmr_inc[15:0];
            if (tmr_inc == TMO) begin
               state_d     = S_ERR;
               error_d     = 1'b1;
               cpu_rst_n_d = 1'b0;
            end
         end
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               state_d     = S_LEN;
               done_d      = 1'b0;
               error_d     = 1'b0;
               cpu_rst_n_d = 1'b0;
               idx_d       = '0;
               csum_d      = '0;
               timer_d     = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               len_d   = bus.byte_in;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               mem_write_d = 1'b1;
               mem_addr_d  = LOAD_BASE + idx_q;
               mem_data_d  = bus.byte_in;
               csum_d      = csum_q + bus.byte_in;
               idx_d       = idx_q + 1'b1;
               // len 0 wraps to an all-ones last index, giving a full 256-byte frame
               if (idx_q == len_q - 1'b1) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (bus.byte_in == csum_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         timer_q     <= '0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         csum_q      <= csum_d;
         timer_q     <= timer_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.byte_ready = ready;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_data   = mem_data_q;
   assign bus.cpu_rst_n  = cpu_rst_n_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader built with load base F0 and an 8-cycle idle timeout.
module tb_prog_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prog_loader_if #(.W(8)) bus ();

   prog_loader #(
      .WORD_SIZE     (8),
      .LOAD_BASE     (8'hF0),
      .TIMEOUT_CYCLES(8)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   logic [7:0] mem [256];

   // Memory unit model: captures the strobe on the edge after it is presented.
   always @(posedge clk) begin
      if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_data;
         wr_cnt            <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
      chk(tag, {bus.mem_write, bus.mem_addr, bus.mem_data}, {1'b1, a, d});
   endtask

   // Presents one byte; returns 1 time unit after its acceptance edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      chk("ready", bus.byte_ready, 1'b1);
      @(posedge clk);
      #1 bus.byte_valid = 1'b0;
   endtask

   task automatic go();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("start", {bus.cpu_rst_n, bus.done, bus.error, bus.byte_ready}, 4'b0001);
   endtask

   initial begin
      int w0;
      int bad;
      bus.start      = 1'b0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;

      #3;
      chk("reset_outs", {bus.byte_ready, bus.mem_write, bus.mem_addr, bus.mem_data,
                         bus.cpu_rst_n, bus.done, bus.error}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // nominal frame
      w0 = wr_cnt;
      go();
      send(8'h03);
      send(8'hA1); chk_wr("nom_w0", 8'hF0, 8'hA1);
      send(8'hB2); chk_wr("nom_w1", 8'hF1, 8'hB2);
      send(8'hC3); chk_wr("nom_w2", 8'hF2, 8'hC3);
      chk("nom_held", bus.cpu_rst_n, 1'b0);
      send(8'h16);
      chk("nom_done", {bus.done, bus.cpu_rst_n, bus.error, bus.mem_write}, 4'b1100);
      chk("nom_cnt", wr_cnt - w0, 3);
      chk("nom_mem", {mem[8'hF0], mem[8'hF1], mem[8'hF2]}, 24'hA1B2C3);

      // restart from DONE, then a bad checksum
      w0 = wr_cnt;
      go();
      send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
      send(8'h17);
      chk("bad_status", {bus.done, bus.cpu_rst_n, bus.error}, 3'b001);
      chk("bad_cnt", wr_cnt - w0, 3);

      // N=0 means 256 bytes, addresses wrap past FF
      w0 = wr_cnt;
      go();
      send(8'h00);
      for (int i = 0; i < 256; i++) begin
         send(8'(i));
         if (i == 0)   chk_wr("wrap_first", 8'hF0, 8'h00);
         if (i == 15)  chk_wr("wrap_ff",    8'hFF, 8'h0F);
         if (i == 16)  chk_wr("wrap_00",    8'h00, 8'h10);
         if (i == 255) chk_wr("wrap_last",  8'hEF, 8'hFF);
      end
      send(8'h80);
      chk("wrap_done", {bus.done, bus.cpu_rst_n, bus.error}, 3'b110);
      chk("wrap_cnt", wr_cnt - w0, 256);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[8'(8'hF0 + i)] !== 8'(i)) bad++;
      chk("wrap_data", bad, 0);

      // random gaps shorter than the timeout
      go();
      repeat ($urandom_range(0, 7)) @(posedge clk);
      send(8'h04);
      for (int i = 1; i <= 4; i++) begin
         repeat ($urandom_range(0, 7)) @(posedge clk);
         send(8'(i * 16));
      end
      repeat (7) @(posedge clk);
      send(8'hA0);
      chk("gap_done", {bus.done, bus.cpu_rst_n, bus.error}, 3'b110);
      chk("gap_mem", {mem[8'hF0], mem[8'hF1], mem[8'hF2], mem[8'hF3]}, 32'h10203040);

      // timeout after two data bytes
      go();
      send(8'h05); send(8'h11); send(8'h22);
      repeat (7) @(posedge clk);
      #1 chk("tmo_early", {bus.error, bus.byte_ready}, 2'b01);
      @(posedge clk);
      #1 chk("tmo_err", {bus.error, bus.done, bus.cpu_rst_n, bus.byte_ready}, 4'b1000);
      chk("tmo_mem", {mem[8'hF0], mem[8'hF1]}, 16'h1122);

      // reset mid-DATA, then a full reload
      go();
      send(8'h05); send(8'hAA); send(8'hBB);
      #1 rst = 1'b1;
      #1 chk("rst_mid", {bus.byte_ready, bus.mem_write, bus.mem_addr, bus.mem_data,
                         bus.cpu_rst_n, bus.done, bus.error}, 0);
      @(negedge clk);
      rst = 1'b0;
      go();
      send(8'h05);
      for (int i = 1; i <= 5; i++) send(8'(i));
      send(8'h0F);
      chk("reload_done", {bus.done, bus.cpu_rst_n, bus.error}, 3'b110);
      chk("reload_mem", {mem[8'hF0], mem[8'hF1], mem[8'hF2], mem[8'hF3], mem[8'hF4]},
          40'h0102030405);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
